// File: rtl/modulo_mux_scan_param.sv
// N:1 bit selector (registered, index i -> A[N_INPUTS-1-i]) with a serial valid/ready scanner over a snapshot of A.
// Latency: direct mode 1 cycle; scan element valid DWELL cycles after it loads, one element per DWELL+1 cycles at full rate.
// Backpressure: out/idx/out_valid held while out_ready is low; no drop, no timeout. Optional parity element via SCAN_MUX_PARITY_EN.
module modulo_mux_scan_param #(
  parameter int N_INPUTS = 36,
  parameter int SEL_W    = 6,
  parameter int DWELL    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mode,
  input  logic [N_INPUTS-1:0] A,
  input  logic [SEL_W-1:0]    input_sel,
  input  logic                start,
  output logic                out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SEL_W-1:0]    idx,
  output logic                busy,
  output logic                done
);

`ifdef SCAN_MUX_PARITY_EN
  // Extra element after the data bits carries the XOR of the snapshot.
  localparam int LAST = N_INPUTS;
`else
  localparam int LAST = N_INPUTS - 1;
`endif
  // Dwell counter only needs to reach DWELL-1.
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DWELL_WAIT = 2'd1,
    PRESENT    = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t              state;
  logic [N_INPUTS-1:0] shadow;
  logic [DW_W-1:0]     dwell;
  logic                dir_bit;
  logic                nxt_bit;
  logic [SEL_W-1:0]    nxt_idx;

  // Direct-mode mux; out-of-range selects fall through to 0.
  always_comb begin
    dir_bit = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (input_sel == SEL_W'(i)) dir_bit = A[N_INPUTS-1-i];
    end
  end

  // Bit of the snapshot for the element that loads on the next handshake.
  always_comb begin
    nxt_idx = idx + SEL_W'(1);
    nxt_bit = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (nxt_idx == SEL_W'(i)) nxt_bit = shadow[N_INPUTS-1-i];
    end
`ifdef SCAN_MUX_PARITY_EN
    if (nxt_idx == SEL_W'(N_INPUTS)) nxt_bit = ^shadow;
`endif
  end

  // Scanner FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out       <= 1'b0;
      out_valid <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shadow    <= '0;
      dwell     <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          if (!mode) begin
            idx <= input_sel;
            out <= dir_bit;
          end else if (start) begin
            // Element 0 is taken straight from A since shadow loads on this same edge.
            shadow <= A;
            idx    <= '0;
            out    <= A[N_INPUTS-1];
            busy   <= 1'b1;
            dwell  <= '0;
            state  <= DWELL_WAIT;
          end
        end
        DWELL_WAIT: begin
          if (dwell == DW_W'(DWELL - 1)) begin
            out_valid <= 1'b1;
            state     <= PRESENT;
          end else begin
            dwell <= dwell + DW_W'(1);
          end
        end
        PRESENT: begin
          // out_valid is always high here, so out_ready alone completes the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == SEL_W'(LAST)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= nxt_idx;
              out   <= nxt_bit;
              dwell <= '0;
              state <= DWELL_WAIT;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_mux_scan_param.sv
// Testbench for modulo_mux_scan_param: direct-select and scan streaming against a list-based model.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Covers reset, direct mapping/out-of-range, scan order, dwell, stall, disturbance, mid-scan reset.
module tb_modulo_mux_scan_param;
  localparam int N     = 36;
  localparam int SW    = 6;
  localparam int DW    = 1;
`ifdef SCAN_MUX_PARITY_EN
  localparam int TOTAL = N + 1;
`else
  localparam int TOTAL = N;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic [N-1:0]  A;
  logic [SW-1:0] input_sel;
  logic          start;
  logic          out;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] idx;
  logic          busy;
  logic          done;

  int n_chk = 0;
  int n_bad = 0;

  modulo_mux_scan_param #(.N_INPUTS(N), .SEL_W(SW), .DWELL(DW)) dut (
    .clk(clk), .reset(reset), .mode(mode), .A(A), .input_sel(input_sel),
    .start(start), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .idx(idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Direct-mode reference: index s picks bit N-1-s, anything past the end reads 0.
  function automatic logic ref_dir(input logic [N-1:0] a, input int s);
    if (s >= N) return 1'b0;
    return a[N-1-s];
  endfunction

  function automatic logic [N-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[N-1:0];
  endfunction

  task automatic direct_check(input logic [N-1:0] a, input int s);
    mode = 1'b0; A = a; input_sel = SW'(s);
    step();
    chk("direct_out", out, ref_dir(a, s));
    chk("direct_idx", idx, s);
    chk("direct_valid", out_valid, 0);
    chk("direct_busy", busy, 0);
  endtask

  // rdy_mode: 0 always ready, 1 five-cycle stall at idx 7, 2 random ready.
  task automatic run_scan(input logic [N-1:0] a, input int rdy_mode, input bit disturb, input bit abort);
    int exp_bits[$];
    int k = 0, since_load = 0, done_cnt = 0, stall_left = 0;
    bit stalled = 0, prev_valid = 0, prev_stall = 0, finished = 0, disturbed = 0, hs;
    for (int i = 0; i < N; i++) exp_bits.push_back(int'(a[N-1-i]));
`ifdef SCAN_MUX_PARITY_EN
    exp_bits.push_back(int'(^a));
`endif
    A = a; mode = 1'b1; start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("scan_busy", busy, 1);
    chk("scan_valid_low_at_load", out_valid, 0);
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (abort && k == 20) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_out", out, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_idx", idx, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        for (int j = 0; j < 3; j++) begin
          step();
          chk("abort_no_done", done, 0);
          chk("abort_idle", busy, 0);
        end
        finished = 1;
      end else begin
        if (out_valid && k < TOTAL) begin
          chk("elem_bit", out, exp_bits[k]);
          chk("elem_idx", idx, k);
        end
        if (prev_stall) chk("stall_valid_held", out_valid, 1);
        if (out_valid && !prev_valid) chk("dwell_len", since_load, DW);
        if (done_cnt > 0 && !done) begin
          chk("busy_after_done", busy, 0);
          finished = 1;
        end
        if (done) begin
          done_cnt++;
          chk("done_after_all", k, TOTAL);
          chk("done_valid_low", out_valid, 0);
          chk("done_idx_last", idx, TOTAL - 1);
        end
        if (!finished) begin
          if (rdy_mode == 1 && out_valid && idx == 7 && !stalled) begin
            stall_left = 5;
            stalled = 1;
          end
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = (rdy_mode == 2) ? 1'($urandom_range(1, 0)) : 1'b1;
          end
          hs = out_valid && out_ready;
          prev_stall = out_valid && !out_ready;
          prev_valid = out_valid;
          if (disturb && k == 10 && !disturbed) begin
            A = rand_word(); start = 1'b1; mode = 1'b0;
            input_sel = SW'($urandom_range(63, 0));
            disturbed = 1;
          end
          step();
          start = 1'b0; mode = 1'b1;
          if (hs) begin
            k++;
            since_load = 0;
          end else begin
            since_load++;
          end
        end
      end
    end
    if (!abort) begin
      chk("scan_count", k, TOTAL);
      chk("done_count", done_cnt, 1);
    end
    if (!finished) chk("scan_timeout", 0, 1);
    out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; A = '0; input_sel = '0; start = 1'b0; out_ready = 1'b1;
    step();
    step();
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_idx", idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    direct_check(36'h8_0000_0001, 0);
    direct_check(36'h8_0000_0001, 35);
    direct_check(36'h8_0000_0001, 1);
    direct_check(36'h8_0000_0001, 40);
    for (int i = 0; i < 24; i++) direct_check(rand_word(), int'($urandom_range(63, 0)));

    run_scan(36'hA_5A5A_5A5A, 0, 0, 0);
    run_scan(rand_word(), 1, 0, 0);
    run_scan(rand_word(), 2, 1, 0);
    run_scan(rand_word(), 0, 0, 1);
    run_scan(36'h0_0000_0007, 0, 0, 0);
    run_scan(36'h0_0000_000F, 2, 0, 0);
    for (int i = 0; i < 3; i++) run_scan(rand_word(), 2, 1, 0);

    for (int i = 0; i < 8; i++) direct_check(rand_word(), int'($urandom_range(63, 0)));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
